// File: rtl/io_uart_pkg.sv
// io_uart_pkg: shared state encoding and baud timing helpers
// for the io_uart receive path.
package io_uart_pkg;

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_rx_state_t;

  function automatic int bit_period(input int clock_freq,
                                    input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

  function automatic int half_period(input int clock_freq,
                                     input int baud_rate);
    return bit_period(clock_freq, baud_rate) / 2;
  endfunction

endpackage

// File: rtl/io_uart_rx_sampler.sv
// io_uart_rx_sampler: line synchronizer, bit-centre counter
// and 3-sample majority vote around each bit centre.
module io_uart_rx_sampler
  import io_uart_pkg::*;
#(
  parameter int BIT_PERIOD  = 16,
  parameter int HALF_PERIOD = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rxd,
  input  logic start,
  input  logic run,
  output logic rxs,
  output logic bit_strobe,
  output logic bit_value
);

  localparam int CW = $clog2(BIT_PERIOD + 1);

  logic          sync1;
  logic [CW-1:0] cnt;
  logic          s_a;
  logic          s_b;
  logic          pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
      cnt   <= '0;
      s_a   <= 1'b1;
      s_b   <= 1'b1;
      pend  <= 1'b0;
    end else begin
      sync1 <= rxd;
      rxs   <= sync1;
      pend  <= 1'b0;
      if (start) begin
        cnt <= CW'(HALF_PERIOD);
      end else if (run) begin
        if (cnt == CW'(1)) s_a <= rxs;
        // Free-running reload keeps every later centre BIT_PERIOD apart.
        if (cnt == '0) begin
          s_b  <= rxs;
          pend <= 1'b1;
          cnt  <= CW'(BIT_PERIOD - 1);
        end else begin
          cnt <= cnt - CW'(1);
        end
      end
    end
  end

  assign bit_strobe = pend & run;
  assign bit_value  = (s_a & s_b) | (s_a & rxs) | (s_b & rxs);

endmodule

// File: rtl/io_uart_receiver.sv
// io_uart_receiver: UART frame receiver with error flags and FIFO.
// Define IO_UART_RX_PARITY_EN to expect and check one parity bit.
module io_uart_receiver
  import io_uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 100000000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 TXD,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 overrun,
  output logic                 break_det,
  output logic                 busy
);

  localparam int BIT_PERIOD  = bit_period(CLOCK_FREQ, BAUD_RATE);
  localparam int HALF_PERIOD = half_period(CLOCK_FREQ, BAUD_RATE);
  localparam int AW = $clog2(FIFO_DEPTH);
`ifdef IO_UART_RX_PARITY_EN
  localparam int WW = DATA_BITS + 2;
`else
  localparam int WW = DATA_BITS + 1;
`endif
  localparam logic [AW:0] PTR_ONE = 1;

  if (BIT_PERIOD < 8 || DATA_BITS < 5 || DATA_BITS > 9 ||
      STOP_BITS < 1 || STOP_BITS > 2 ||
      PARITY_ODD < 0 || PARITY_ODD > 1 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("io_uart_receiver: illegal parameter set");
  end

  uart_rx_state_t       state;
  logic                 rxs;
  logic                 bit_strobe;
  logic                 bit_value;
  logic [DATA_BITS-1:0] shreg;
  logic [3:0]           bit_idx;
  logic                 stop_idx;
  logic                 ferr;
  logic                 stop0;
  logic                 last_stop;
  logic                 first0;
  logic                 brk;
  logic                 frame_bad;
  logic [WW-1:0]        word;
  logic [WW-1:0]        mem [FIFO_DEPTH];
  logic [WW-1:0]        head;
  logic [AW:0]          wptr;
  logic [AW:0]          rptr;
  logic                 full;
  logic                 pop;
  logic                 wr;
`ifdef IO_UART_RX_PARITY_EN
  logic                 par_bit;
  logic                 parity_bad;
`endif

  io_uart_rx_sampler #(
    .BIT_PERIOD (BIT_PERIOD),
    .HALF_PERIOD(HALF_PERIOD)
  ) u_sampler (
    .clk       (clk),
    .rst_n     (rst_n),
    .rxd       (TXD),
    .start     ((state == IDLE) && !rxs),
    .run       ((state != IDLE) && (state != WAIT_IDLE)),
    .rxs       (rxs),
    .bit_strobe(bit_strobe),
    .bit_value (bit_value)
  );

  assign last_stop = (state == STOP) && bit_strobe &&
                     (stop_idx == 1'(STOP_BITS - 1));
  assign first0    = (stop_idx == 1'b0) ? !bit_value : stop0;
  assign frame_bad = ferr | !bit_value;
`ifdef IO_UART_RX_PARITY_EN
  assign parity_bad = ^{shreg, par_bit, 1'(PARITY_ODD)};
  assign brk  = (shreg == '0) && !par_bit && first0;
  assign word = {shreg, frame_bad, parity_bad};
`else
  assign brk  = (shreg == '0) && first0;
  assign word = {shreg, frame_bad};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= WAIT_IDLE;
      shreg     <= '0;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      ferr      <= 1'b0;
      stop0     <= 1'b0;
      break_det <= 1'b0;
`ifdef IO_UART_RX_PARITY_EN
      par_bit   <= 1'b0;
`endif
    end else begin
      break_det <= 1'b0;
      unique case (state)
        WAIT_IDLE: if (rxs) state <= IDLE;
        IDLE:      if (!rxs) state <= START;
        START: if (bit_strobe) begin
          state   <= bit_value ? IDLE : DATA;
          bit_idx <= '0;
        end
        DATA: if (bit_strobe) begin
          shreg   <= {bit_value, shreg[DATA_BITS-1:1]};
          bit_idx <= bit_idx + 4'd1;
          if (bit_idx == 4'(DATA_BITS - 1)) begin
            stop_idx <= 1'b0;
            ferr     <= 1'b0;
`ifdef IO_UART_RX_PARITY_EN
            state    <= PARITY;
`else
            state    <= STOP;
`endif
          end
        end
`ifdef IO_UART_RX_PARITY_EN
        PARITY: if (bit_strobe) begin
          par_bit <= bit_value;
          state   <= STOP;
        end
`endif
        STOP: if (bit_strobe) begin
          if (!bit_value) ferr <= 1'b1;
          if (stop_idx == 1'b0) stop0 <= !bit_value;
          // Push happens at the last stop centre, not at bit end.
          if (last_stop) begin
            break_det <= brk;
            state     <= brk ? WAIT_IDLE : IDLE;
          end else begin
            stop_idx <= 1'b1;
          end
        end
        default: state <= WAIT_IDLE;
      endcase
    end
  end

  assign rx_valid = (wptr != rptr);
  assign full = (wptr[AW] != rptr[AW]) &&
                (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop  = rx_valid & rx_ready;
  assign wr   = last_stop && (!full || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= last_stop && full && !pop;
      if (wr)  wptr <= wptr + PTR_ONE;
      if (pop) rptr <= rptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wptr[AW-1:0]] <= word;
  end

  assign head    = mem[rptr[AW-1:0]];
  assign rx_data = rx_valid ? head[WW-1 -: DATA_BITS] : '0;
`ifdef IO_UART_RX_PARITY_EN
  assign rx_frame_err  = rx_valid & head[1];
  assign rx_parity_err = rx_valid & head[0];
`else
  assign rx_frame_err  = rx_valid & head[0];
  assign rx_parity_err = 1'b0;
`endif
  assign busy = (state != IDLE);

endmodule
